// File: rtl/serializer.sv
// Parallel-to-serial converter: captures one block of N_SAMPLES words in a single
// handshake, then streams them out index 0 first on a val/rdy interface.
module serializer #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_last
);

    localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_next;
    logic                 w_capture;
    logic [BIT_WIDTH-1:0] r_data [N_SAMPLES];

    // NOTE: every branch assigns defaults first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_capture    = 1'b0;
        recv_rdy     = 1'b0;
        send_val     = 1'b0;
        send_msg     = '0;
        send_last    = 1'b0;

        case (r_state)
            IDLE: begin
                // Gated by reset so the block never looks ready while held in reset.
                recv_rdy = reset;
                if (recv_val && reset) begin
                    w_capture    = 1'b1;
                    w_count_next = '0;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                send_val  = 1'b1;
                send_msg  = r_data[r_count];
                send_last = (r_count == LAST_IDX);
                if (send_rdy) begin
                    if (r_count == LAST_IDX) begin
                        w_count_next = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // NOTE: the capture registers are reset too, so send_msg never exposes a stale block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SAMPLES; i++) r_data[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < N_SAMPLES; i++) r_data[i] <= recv_msg[i];
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench: a 4-word and a 1-word serializer driven side by side and
// compared every cycle against a queue-based model of the expected word stream.
module tb_serializer;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         rv, rr, sv, sr, sl;
    logic [W-1:0] rm [N];
    logic [W-1:0] sm;
    logic [W-1:0] nxt [N];

    logic         rv1, rr1, sv1, sr1, sl1;
    logic [W-1:0] rm1 [1];
    logic [W-1:0] sm1;
    logic [W-1:0] nxt1 [1];

    // Words still owed by each DUT, oldest first; empty means the DUT should be idle.
    logic [W-1:0] q  [$];
    logic [W-1:0] q1 [$];

    int n_checks = 0;
    int n_pass   = 0;

    serializer #(.N_SAMPLES(N), .BIT_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .recv_val(rv), .recv_rdy(rr), .recv_msg(rm),
        .send_val(sv), .send_rdy(sr), .send_msg(sm), .send_last(sl)
    );

    serializer #(.N_SAMPLES(1), .BIT_WIDTH(W)) dut1 (
        .clk(clk), .reset(reset),
        .recv_val(rv1), .recv_rdy(rr1), .recv_msg(rm1),
        .send_val(sv1), .send_rdy(sr1), .send_msg(sm1), .send_last(sl1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        check("n4_recv_rdy",  rr, reset && q.size() == 0);
        check("n4_send_val",  sv, q.size() != 0);
        check("n4_send_msg",  sm, (q.size() != 0) ? q[0] : 8'h00);
        check("n4_send_last", sl, q.size() == 1);
        check("n1_recv_rdy",  rr1, reset && q1.size() == 0);
        check("n1_send_val",  sv1, q1.size() != 0);
        check("n1_send_msg",  sm1, (q1.size() != 0) ? q1[0] : 8'h00);
        check("n1_send_last", sl1, q1.size() == 1);
    endtask

    // One clock cycle: check outputs at the falling edge, drive new inputs, advance the model.
    task automatic step(input logic v, input logic s, input logic v1, input logic s1);
        @(negedge clk);
        check_outputs();
        rv  = v;  sr  = s;  rm  = nxt;
        rv1 = v1; sr1 = s1; rm1 = nxt1;
        if (reset) begin
            if (q.size() == 0) begin
                if (v) for (int i = 0; i < N; i++) q.push_back(nxt[i]);
            end else if (s) begin
                void'(q.pop_front());
            end
            if (q1.size() == 0) begin
                if (v1) q1.push_back(nxt1[0]);
            end else if (s1) begin
                void'(q1.pop_front());
            end
        end
    endtask

    task automatic set_block(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        nxt[0] = a; nxt[1] = b; nxt[2] = c; nxt[3] = d;
    endtask

    initial begin
        logic [6:0] rdy_pat;
        reset = 1'b0;
        rv = 1'b0; sr = 1'b0; rv1 = 1'b0; sr1 = 1'b0;
        set_block(8'h00, 8'h00, 8'h00, 8'h00);
        nxt1[0] = 8'h00;
        rm = nxt; rm1 = nxt1;

        // Reset held for two cycles, released away from the clock edge.
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        rv = 1'b0; rv1 = 1'b0;

        // Block with send_rdy high throughout.
        set_block(8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Same block under back-pressure.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rdy_pat = 7'b1011001;
        for (int i = 0; i < 7; i++) step(1'b0, rdy_pat[i], 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Input changes and recv_val pulses while sending are ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        set_block(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-block after 0x22 is accepted.
        set_block(8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_send_val",  sv, 1'b0);
        check("rst_recv_rdy",  rr, 1'b0);
        check("rst_send_msg",  sm, 8'h00);
        check("rst_send_last", sl, 1'b0);
        q.delete();
        q1.delete();
        rv = 1'b0; sr = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        set_block(8'h01, 8'h02, 8'h03, 8'h04);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Single-word build: second block accepted two cycles after the first capture.
        nxt1[0] = 8'h5A;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        nxt1[0] = 8'hC3;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) nxt[i] = W'($urandom);
            nxt1[0] = W'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        // Drain and confirm both return to idle.
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
